// File: rtl/hazard_control_if.sv
// Hazard-control bundle: pipeline status in, pipeline control and statistics out.
// The master drives the pipeline-status side; the slave is the hazard unit.
interface hazard_control_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) ();
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_load;
  logic             branch_taken;
  logic             mem_busy;
  logic             clr_cnt;
  logic             pc_le;
  logic             ifid_le;
  logic             flush_ifid;
  logic             mux_flush;
  logic             mux_stall;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load,
           branch_taken, mem_busy, clr_cnt,
    input  pc_le, ifid_le, flush_ifid, mux_flush, mux_stall,
           state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load,
           branch_taken, mem_busy, clr_cnt,
    output pc_le, ifid_le, flush_ifid, mux_flush, mux_stall,
           state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// memory-wait freezes, with saturating stall/flush statistics counters.
// Control outputs are combinational from the current state and inputs.
module hazard_control #(
  parameter int REG_W           = 4,
  parameter int CNT_W           = 16,
  parameter int BR_FLUSH_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  hazard_control_if.slave  hz
);

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LU  = 2'd1;
  localparam logic [1:0] S_BRF = 2'd2;
  localparam logic [1:0] S_MW  = 2'd3;

  // Remaining flush cycles loaded after the branch cycle itself.
  localparam logic [1:0] BRF_RELOAD = 2'(BR_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       brf_cnt_q, brf_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_le, ifid_le, flush_ifid, mux_flush, mux_stall;

  logic [REG_W-1:0] rs1, rs2, rd;
  logic             lu;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign rd  = hz.ex_rd;

  // Load-use hazard: a load in EX writes a nonzero register that ID reads.
  assign lu = hz.ex_load && (rd != '0) &&
              ((hz.id_use_rs1 && (rs1 == rd)) || (hz.id_use_rs2 && (rs2 == rd)));

  // Control outputs and next state, prioritised reset > busy > branch/BRF > load-use.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    brf_cnt_d  = brf_cnt_q;
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    flush_ifid = 1'b0;
    mux_flush  = 1'b0;
    mux_stall  = 1'b0;

    if (!rst_n) begin
      // NOP injection while held in reset.
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      flush_ifid = 1'b1;
      mux_flush  = 1'b1;
      state_d    = S_RUN;
      brf_cnt_d  = 2'd0;
    end else if (hz.mem_busy) begin
      // Freeze; any pending flush count is held for after the wait.
      pc_le     = 1'b0;
      ifid_le   = 1'b0;
      mux_stall = 1'b1;
      state_d   = S_MW;
    end else if (hz.branch_taken) begin
      flush_ifid = 1'b1;
      mux_flush  = 1'b1;
      brf_cnt_d  = BRF_RELOAD;
      state_d    = (BRF_RELOAD != 2'd0) ? S_BRF : S_RUN;
    end else begin
      case (state_q)
        S_BRF: begin
          flush_ifid = 1'b1;
          mux_flush  = 1'b1;
          if (brf_cnt_q <= 2'd1) begin
            brf_cnt_d = 2'd0;
            state_d   = S_RUN;
          end else begin
            brf_cnt_d = brf_cnt_q - 2'd1;
            state_d   = S_BRF;
          end
        end
        S_MW: begin
          // Leaving a wait: resume a held flush, otherwise behave as RUN.
          if (brf_cnt_q != 2'd0) begin
            state_d = S_BRF;
          end else if (lu) begin
            pc_le     = 1'b0;
            ifid_le   = 1'b0;
            mux_flush = 1'b1;
            state_d   = S_LU;
          end else begin
            state_d = S_RUN;
          end
        end
        S_LU: begin
          // Load has moved on; detection is masked for this one cycle.
          state_d = S_RUN;
        end
        default: begin
          if (lu) begin
            pc_le     = 1'b0;
            ifid_le   = 1'b0;
            mux_flush = 1'b1;
            state_d   = S_LU;
          end else begin
            state_d = S_RUN;
          end
        end
      endcase
    end
  end

  // Saturating statistics counters; a clear wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_le && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (mux_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, flush count and counters registered with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: counters are control state (not a RAM), so they take the async reset like any other flop.
    if (!rst_n) begin
      state_q     <= S_RUN;
      brf_cnt_q   <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      brf_cnt_q   <= brf_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_le      = pc_le;
  assign hz.ifid_le    = ifid_le;
  assign hz.flush_ifid = flush_ifid;
  assign hz.mux_flush  = mux_flush;
  assign hz.mux_stall  = mux_stall;
  assign hz.state_o    = state_q;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Testbench for hazard_control: directed scenarios followed by random
// stimulus, checked every cycle against a behavioural reference model.
module tb_hazard_control;

  localparam int REG_W = 4;
  localparam int CNT_W = 6;
  localparam int BR    = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef enum {A_NORMAL, A_STALL, A_FLUSH, A_BUBBLE} act_t;

  logic clk;
  logic rst_n;

  hazard_control_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_control #(
    .REG_W          (REG_W),
    .CNT_W          (CNT_W),
    .BR_FLUSH_CYCLES(BR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: flushes still owed, frozen by memory wait, load-use masked.
  int flush_left;
  bit frozen;
  bit lu_masked;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_lu();
    if (!hz.ex_load || hz.ex_rd == 0) return 1'b0;
    return (hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
           (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd);
  endfunction

  function automatic act_t decide();
    if (hz.mem_busy)                 return A_STALL;
    if (hz.branch_taken)             return A_FLUSH;
    if (flush_left > 0 && !frozen)   return A_FLUSH;
    if (flush_left > 0)              return A_NORMAL;
    if (ref_lu() && !lu_masked)      return A_BUBBLE;
    return A_NORMAL;
  endfunction

  function automatic int exp_state();
    if (frozen)         return 3;
    if (flush_left > 0) return 2;
    if (lu_masked)      return 1;
    return 0;
  endfunction

  task automatic model_reset();
    flush_left = 0;
    frozen     = 1'b0;
    lu_masked  = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic model_commit(input act_t a);
    bit stalled, flushed;
    stalled = (a == A_STALL) || (a == A_BUBBLE);
    flushed = (a == A_FLUSH) || (a == A_BUBBLE);
    if (hz.mem_busy) begin
      frozen    = 1'b1;
      lu_masked = 1'b0;
    end else if (hz.branch_taken) begin
      flush_left = BR - 1;
      frozen     = 1'b0;
      lu_masked  = 1'b0;
    end else if (flush_left > 0 && !frozen) begin
      flush_left--;
    end else begin
      frozen    = 1'b0;
      lu_masked = (a == A_BUBBLE);
    end
    if (hz.clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (stalled && m_stall < CMAX) m_stall++;
      if (flushed && m_flush < CMAX) m_flush++;
    end
  endtask

  task automatic check_outputs(input string tag, input bit pc, input bit fi, input bit mf,
                               input bit ms, input int st, input int sc, input int fc);
    check({tag, ".pc_le"},      32'(hz.pc_le),      32'(pc));
    check({tag, ".ifid_le"},    32'(hz.ifid_le),    32'(pc));
    check({tag, ".flush_ifid"}, 32'(hz.flush_ifid), 32'(fi));
    check({tag, ".mux_flush"},  32'(hz.mux_flush),  32'(mf));
    check({tag, ".mux_stall"},  32'(hz.mux_stall),  32'(ms));
    check({tag, ".state_o"},    32'(hz.state_o),    32'(st));
    check({tag, ".stall_cnt"},  32'(hz.stall_cnt),  32'(sc));
    check({tag, ".flush_cnt"},  32'(hz.flush_cnt),  32'(fc));
    check({tag, ".excl"},       32'(hz.mux_flush & hz.mux_stall), 32'd0);
  endtask

  // One clock cycle: inputs already driven, check combinational outputs, advance.
  task automatic step(input string tag);
    act_t a;
    #1;
    a = decide();
    case (a)
      A_STALL:  check_outputs(tag, 1'b0, 1'b0, 1'b0, 1'b1, exp_state(), m_stall, m_flush);
      A_FLUSH:  check_outputs(tag, 1'b1, 1'b1, 1'b1, 1'b0, exp_state(), m_stall, m_flush);
      A_BUBBLE: check_outputs(tag, 1'b0, 1'b0, 1'b1, 1'b0, exp_state(), m_stall, m_flush);
      default:  check_outputs(tag, 1'b1, 1'b0, 1'b0, 1'b0, exp_state(), m_stall, m_flush);
    endcase
    @(posedge clk);
    model_commit(a);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hz.id_rs1       = '0;
    hz.id_rs2       = '0;
    hz.id_use_rs1   = 1'b0;
    hz.id_use_rs2   = 1'b0;
    hz.ex_rd        = '0;
    hz.ex_load      = 1'b0;
    hz.branch_taken = 1'b0;
    hz.mem_busy     = 1'b0;
    hz.clr_cnt      = 1'b0;
  endtask

  // Assert reset between clock edges, check NOP injection, release away from an edge.
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"}, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_outputs({tag, ".held"}, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step("idle");
    step("idle");

    // Load-use on rs2: one bubble, then LU with normal outputs despite same inputs.
    hz.ex_load = 1'b1; hz.ex_rd = 4'd5; hz.id_rs2 = 4'd5; hz.id_use_rs2 = 1'b1;
    step("lu_hit");
    step("lu_masked");
    step("lu_again");
    idle_inputs();
    step("lu_done");

    // Same hazard pattern but destination x0: never a stall.
    hz.ex_load = 1'b1; hz.ex_rd = 4'd0; hz.id_rs2 = 4'd0; hz.id_use_rs2 = 1'b1;
    step("lu_x0");
    step("lu_x0");
    idle_inputs();

    // Branch pulse: three flush cycles, then back to RUN.
    hz.clr_cnt = 1'b1;
    step("clr");
    hz.clr_cnt = 1'b0;
    hz.branch_taken = 1'b1;
    step("br0");
    hz.branch_taken = 1'b0;
    step("br1");
    step("br2");
    step("br_done");

    // Branch with simultaneous load-use, then two busy cycles inside BRF.
    hz.branch_taken = 1'b1;
    hz.ex_load = 1'b1; hz.ex_rd = 4'd3; hz.id_rs1 = 4'd3; hz.id_use_rs1 = 1'b1;
    step("brlu");
    idle_inputs();
    hz.mem_busy = 1'b1;
    step("brf_busy0");
    step("brf_busy1");
    hz.mem_busy = 1'b0;
    step("mw_exit");
    step("brf_resume0");
    step("brf_resume1");
    step("brf_end");

    // Hold busy long enough to saturate stall_cnt, then clear while still busy.
    hz.mem_busy = 1'b1;
    for (int i = 0; i < CMAX + 8; i++) step("sat");
    hz.clr_cnt = 1'b1;
    step("sat_clr");
    hz.clr_cnt = 1'b0;
    step("after_clr");

    // Reset in the middle of a memory wait.
    step("mw_pre_rst");
    reset_mid("rst_mw");
    step("post_rst");

    // Reset in the middle of a branch flush.
    hz.branch_taken = 1'b1;
    step("br_pre_rst");
    hz.branch_taken = 1'b0;
    reset_mid("rst_brf");
    step("post_rst2");

    // Random traffic with a small register space so hazards are frequent.
    for (int i = 0; i < 2000; i++) begin
      hz.id_rs1       = REG_W'($urandom_range(3, 0));
      hz.id_rs2       = REG_W'($urandom_range(3, 0));
      hz.ex_rd        = REG_W'($urandom_range(3, 0));
      hz.id_use_rs1   = 1'($urandom_range(1, 0));
      hz.id_use_rs2   = 1'($urandom_range(1, 0));
      hz.ex_load      = 1'($urandom_range(1, 0));
      hz.branch_taken = ($urandom_range(99, 0) < 10);
      hz.mem_busy     = ($urandom_range(99, 0) < 15);
      hz.clr_cnt      = ($urandom_range(99, 0) < 2);
      if ($urandom_range(499, 0) == 0) begin
        reset_mid("rand_rst");
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
